peak_readout_serializer: RTL
============================

Name: peak_readout_serializer

Overview:
- Downstream consumer of the histogram builder / peak detector's packed per-pixel peak vector.
- Captures each completed frame's PIXEL_NUM peak timestamps into a two-frame ping-pong buffer.
- Streams the captured frame out one pixel per beat over a valid/ready interface to the readout/host link.
- Decouples the histogram pipeline's frame timing from readout back-pressure, and accounts for dropped frames.

Parameters:
- NP, 10, peak timestamp width in bits (matches the timestamp width `Np).
- PIXEL_NUM, 4, pixels per packed result vector (matches `PIXEL_NUM_PER_RAM).
- PIX_W, $clog2(PIXEL_NUM), width of the pixel index (derived).
- FID_W, 4, width of the frame tag.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- res, input, 1: asynchronous, active-high reset.
- frame_done, input, 1: one-cycle strobe meaning `result` holds a new, complete frame.
- result, input, NP*PIXEL_NUM: packed peaks; pixel p occupies [p*NP +: NP].
- out_valid, output, 1: beat available.
- out_ready, input, 1: consumer accepts the beat.
- out_data, output, NP: peak timestamp of the current pixel.
- out_nohit, output, 1: high when out_data equals all-ones (no-hit marker).
- out_pixel, output, PIX_W: pixel index of the current beat.
- out_last, output, 1: high on the beat for pixel PIXEL_NUM-1.
- out_fid, output, FID_W: tag of the frame being streamed.
- busy, output, 1: at least one buffer holds an unsent frame.
- drop_cnt, output, 8: saturating count of dropped frames.

Behaviour:
- Reset values (asynchronous, active-high):
  - Both buffer-full flags are 0.
  - out_valid, out_data, out_nohit, out_pixel, out_last, out_fid, busy and drop_cnt are all 0.
  - Write pointer, read pointer and the frame-id counter are 0.
  - Reset mid-stream discards both buffers with no partial flush.
- Capture:
  - On a frame_done edge, the whole `result` vector is copied into the buffer at the write pointer, if that buffer is free.
  - On capture, that buffer is marked full, tagged with the frame-id counter, and the write pointer and frame-id counter both increment (frame-id wraps modulo 2^FID_W).
- Drop:
  - If frame_done arrives while both buffers are full (after applying the same-cycle release rule below), the frame is discarded.
  - On a drop, drop_cnt increments, saturating at 255, and the frame-id counter still increments so the gap is visible downstream.
- Same-cycle release: if the last beat of a buffer handshakes (out_valid & out_ready & out_last) in the same cycle as frame_done, that buffer counts as free and the capture succeeds.
- Read FSM has two states, IDLE and SEND:
  - IDLE -> SEND when the buffer at the read pointer is full. out_valid rises on the next edge with pixel 0.
  - Latency: frame_done at edge N, captured into an empty system, gives out_valid=1 after edge N+1.
  - In SEND, each handshake advances out_pixel by 1.
  - On the last-beat handshake, the buffer is cleared and the read pointer toggles.
  - After the last beat, if the other buffer is full, the FSM stays in SEND and presents pixel 0 of that buffer in the very next cycle (no bubble). Otherwise it goes to IDLE and out_valid drops.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data, out_nohit, out_pixel, out_last and out_fid hold stable.
  - out_valid never drops without a handshake, except on reset.
- Outputs are registered.
  - out_data/out_nohit are taken from the buffer slice at out_pixel.
  - A capture into the other buffer never disturbs the beat being presented.
- busy is the OR of the two buffer-full flags.
- Frames are emitted strictly in capture order.

Decomposition:
- Shared package sifh_pkg holds:
  - the NP and PIXEL_NUM constants;
  - the derived PIX_W;
  - NOHIT = {NP{1'b1}};
  - a peak_t typedef (logic [NP-1:0]);
  - a read-FSM state enum {IDLE, SEND}.
- One natural sub-module, peak_frame_pingpong:
  - contains the two frame registers, the full flags, the write/read pointers and the capture/drop/tag logic;
  - exposes a read-side slice selected by (rd_ptr, pixel) plus a release strobe.
- The serializer FSM stays in the top module.

Test Plan:
- Single frame: result = {3FF,120,045,001} (pixel3..0), frame_done, out_ready=1 -> beats 001,045,120,3FF on pixels 0..3; nohit only on pixel 3; last on pixel 3; fid=0; out_valid first seen 1 cycle after capture.
- Back-pressure: out_ready toggles 1,0,0,1,... during a frame -> each beat holds stable while stalled; exactly 4 handshakes; data identical to the no-stall case.
- Back-to-back frames: frame A (fid 0), then frame B (fid 1) two cycles later, out_ready=1 -> 8 consecutive beats with no bubble; B pixel 0 directly follows A's last beat.
- Overflow: out_ready=0 and three frame_done strobes -> first two captured (fid 0,1); third dropped; drop_cnt=1; after release, fid=3 is the next captured tag.
- Same-cycle release: both buffers full; frame_done coincides with the last-beat handshake -> capture succeeds; drop_cnt unchanged; new frame streamed after the remaining one.
- Reset mid-stream: assert res during pixel 2 -> all outputs 0 immediately (asynchronous); after release the next frame_done starts at pixel 0 with fid 0.

Source files
------------

// File: rtl/sifh_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Package : sifh_pkg
// Brief   : shared constants and types for the peak readout path
// Revision: 1.0
// ------------------------------------------------------------------
package sifh_pkg;

  localparam int NP        = 10;
  localparam int PIXEL_NUM = 4;
  localparam int PIX_W     = $clog2(PIXEL_NUM);

  localparam logic [NP-1:0] NOHIT = {NP{1'b1}};

  typedef logic [NP-1:0] peak_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/peak_frame_pingpong.sv
`default_nettype none
// ------------------------------------------------------------------
// Module  : peak_frame_pingpong
// Brief   : two-frame capture buffer with tags, pointers and drop count
// Revision: 1.0
// ------------------------------------------------------------------
module peak_frame_pingpong #(
  parameter int NP        = 10,
  parameter int PIXEL_NUM = 4,
  parameter int PIX_W     = 2,
  parameter int FID_W     = 4
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    frame_done,
  input  logic [NP*PIXEL_NUM-1:0] result,
  input  logic                    rd_release,
  input  logic                    rd_sel,
  input  logic [PIX_W-1:0]        rd_pixel,
  output logic [NP-1:0]           rd_data,
  output logic [FID_W-1:0]        rd_fid,
  output logic                    rd_full,
  output logic                    rd_ptr,
  output logic                    busy,
  output logic [7:0]              drop_cnt
);

  logic [1:0]              r_full;
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [FID_W-1:0]        r_fid_cnt;
  logic [FID_W-1:0]        r_tag [2];
  logic [NP*PIXEL_NUM-1:0] r_frame [2];
  logic [7:0]              r_drop_cnt;

  logic w_wr_free;
  logic w_capture;
  logic w_drop;

  // When both buffers are full the write pointer equals the read pointer,
  // so a last-beat release frees exactly the buffer we want to write.
  assign w_wr_free = !r_full[r_wr_ptr] || (rd_release && (r_rd_ptr == r_wr_ptr));
  assign w_capture = frame_done && w_wr_free;
  assign w_drop    = frame_done && !w_wr_free;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_full     <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fid_cnt  <= '0;
      r_tag[0]   <= '0;
      r_tag[1]   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (rd_release) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
      end
      if (w_capture) begin
        r_full[r_wr_ptr] <= 1'b1;
        r_tag[r_wr_ptr]  <= r_fid_cnt;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (frame_done) begin
        r_fid_cnt <= r_fid_cnt + FID_W'(1);
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_frame[r_wr_ptr] <= result;
    end
  end

  assign rd_data  = r_frame[rd_sel][int'(rd_pixel) * NP +: NP];
  assign rd_fid   = r_tag[rd_sel];
  assign rd_full  = r_full[rd_sel];
  assign rd_ptr   = r_rd_ptr;
  assign busy     = |r_full;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: rtl/peak_readout_serializer.sv
`default_nettype none
// ------------------------------------------------------------------
// Module  : peak_readout_serializer
// Brief   : captures peak vectors into a ping-pong buffer, streams one pixel per beat
// Revision: 1.0
// ------------------------------------------------------------------
module peak_readout_serializer #(
  parameter int NP        = sifh_pkg::NP,
  parameter int PIXEL_NUM = sifh_pkg::PIXEL_NUM,
  parameter int PIX_W     = $clog2(PIXEL_NUM),
  parameter int FID_W     = 4
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    frame_done,
  input  logic [NP*PIXEL_NUM-1:0] result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NP-1:0]           out_data,
  output logic                    out_nohit,
  output logic [PIX_W-1:0]        out_pixel,
  output logic                    out_last,
  output logic [FID_W-1:0]        out_fid,
  output logic                    busy,
  output logic [7:0]              drop_cnt
);

  import sifh_pkg::*;

  rd_state_t r_state;
  rd_state_t w_state_nxt;

  logic             r_valid;
  logic [NP-1:0]    r_data;
  logic             r_nohit;
  logic [PIX_W-1:0] r_pixel;
  logic             r_last;
  logic [FID_W-1:0] r_fid;

  logic             w_hs;
  logic             w_last_hs;
  logic             w_rd_ptr;
  logic             w_rd_sel;
  logic [PIX_W-1:0] w_rd_pixel;
  logic [NP-1:0]    w_rd_data;
  logic [FID_W-1:0] w_rd_fid;
  logic             w_rd_full;
  logic             w_load;
  logic             w_valid_nxt;

  assign w_hs      = r_valid & out_ready;
  assign w_last_hs = w_hs & r_last;

  // Look ahead to the beat that will be presented after this edge: the other
  // buffer's pixel 0 on a last-beat handshake, otherwise the next pixel.
  assign w_rd_sel   = w_last_hs ? ~w_rd_ptr : w_rd_ptr;
  assign w_rd_pixel = (w_hs && !r_last) ? (r_pixel + PIX_W'(1)) : '0;

  peak_frame_pingpong #(
    .NP        (NP),
    .PIXEL_NUM (PIXEL_NUM),
    .PIX_W     (PIX_W),
    .FID_W     (FID_W)
  ) u_pingpong (
    .clk        (clk),
    .res        (res),
    .frame_done (frame_done),
    .result     (result),
    .rd_release (w_last_hs),
    .rd_sel     (w_rd_sel),
    .rd_pixel   (w_rd_pixel),
    .rd_data    (w_rd_data),
    .rd_fid     (w_rd_fid),
    .rd_full    (w_rd_full),
    .rd_ptr     (w_rd_ptr),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rd_full) w_state_nxt = SEND;
      SEND:    if (w_last_hs && !w_rd_full) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load      = 1'b0;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (w_rd_full) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
        end
      end
      SEND: begin
        if (w_hs) begin
          if (!r_last || w_rd_full) begin
            w_load = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: w_valid_nxt = 1'b0;
    endcase
  end

  // Beat registers only move on a load, so a stalled beat holds untouched.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_nohit <= 1'b0;
      r_pixel <= '0;
      r_last  <= 1'b0;
      r_fid   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_load) begin
        r_data  <= w_rd_data;
        r_nohit <= &w_rd_data;
        r_pixel <= w_rd_pixel;
        r_last  <= (w_rd_pixel == PIX_W'(PIXEL_NUM - 1));
        r_fid   <= w_rd_fid;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_nohit = r_nohit;
  assign out_pixel = r_pixel;
  assign out_last  = r_last;
  assign out_fid   = r_fid;

endmodule
`default_nettype wire
